// File: rtl/rs_cw_buf_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : rs_cw_buf_ctrl                                               |
// | Description : RS(544,522) received-codeword delay buffer controller.       |
// |               Feeds an external sync_fifo and drains one codeword per      |
// |               Chien-side start request with first/last beat markers.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs_cw_buf_ctrl #(
    parameter int BEATS_PER_CW = 34,
    parameter int CNT_WIDTH    = 3,
    parameter int BEAT_WIDTH   = 6
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 fifo_push,
    output logic                 fifo_pull,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    input  logic                 chien_start,
    output logic                 out_valid,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cw_cnt,
    input  logic                 err_clr,
    output logic                 err_underrun,
    output logic                 err_overlap
);

    localparam logic [0:0]            S_IDLE      = 1'b0;
    localparam logic [0:0]            S_DRAIN     = 1'b1;
    localparam logic [BEAT_WIDTH-1:0] C_LAST_BEAT = BEAT_WIDTH'(BEATS_PER_CW - 1);
    localparam logic [BEAT_WIDTH-1:0] C_BEAT_ONE  = BEAT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  C_CNT_ZERO  = '0;

    logic [0:0]            state_q, state_d;
    logic [BEAT_WIDTH-1:0] wr_beat_q, wr_beat_d;
    logic [BEAT_WIDTH-1:0] rd_beat_q, rd_beat_d;
    logic [CNT_WIDTH-1:0]  cw_cnt_q, cw_cnt_d;
    logic                  pending_q, pending_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_first_q, out_first_d;
    logic                  out_last_q, out_last_d;
    logic                  err_underrun_q, err_underrun_d;
    logic                  err_overlap_q, err_overlap_d;

    logic                  rd_end;
    logic                  launch;
    logic                  launch_ok;
    logic                  cw_inc;

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including launch of the next codeword
    always_comb begin
        rd_end    = (state_q == S_DRAIN) && fifo_pull && (rd_beat_q == C_LAST_BEAT);
        launch    = ((state_q == S_IDLE) || rd_end) && (chien_start || pending_q);
        launch_ok = launch && (cw_cnt_q != C_CNT_ZERO);
        state_d   = state_q;
        case (state_q)
            S_IDLE:  state_d = launch_ok ? S_DRAIN : S_IDLE;
            S_DRAIN: if (rd_end) state_d = launch_ok ? S_DRAIN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and handshake logic
    always_comb begin
        in_ready     = !fifo_full;
        fifo_push    = in_valid && !fifo_full;
        fifo_pull    = (state_q == S_DRAIN) && !fifo_empty;
        busy         = (state_q == S_DRAIN);
        out_valid    = out_valid_q;
        out_first    = out_first_q;
        out_last     = out_last_q;
        cw_cnt       = cw_cnt_q;
        err_underrun = err_underrun_q;
        err_overlap  = err_overlap_q;
    end

    // Beat counters, codeword count, pending request and sticky flags
    always_comb begin
        cw_inc    = fifo_push && (wr_beat_q == C_LAST_BEAT);
        wr_beat_d = wr_beat_q;
        if (fifo_push) begin
            wr_beat_d = cw_inc ? '0 : wr_beat_q + C_BEAT_ONE;
        end

        rd_beat_d = rd_beat_q;
        if (launch_ok || rd_end) begin
            rd_beat_d = '0;
        end else if (fifo_pull) begin
            rd_beat_d = rd_beat_q + C_BEAT_ONE;
        end

        cw_cnt_d = cw_cnt_q + {{(CNT_WIDTH-1){1'b0}}, cw_inc}
                            - {{(CNT_WIDTH-1){1'b0}}, launch_ok};

        // A launch consumes the request whether or not a codeword was available
        pending_d = pending_q;
        if (launch) begin
            pending_d = 1'b0;
        end else if (chien_start && (state_q == S_DRAIN)) begin
            pending_d = 1'b1;
        end

        out_valid_d = fifo_pull;
        out_first_d = fifo_pull && (rd_beat_q == '0);
        out_last_d  = fifo_pull && (rd_beat_q == C_LAST_BEAT);

        err_underrun_d = err_underrun_q;
        if ((launch && !launch_ok) || ((state_q == S_DRAIN) && fifo_empty)) begin
            err_underrun_d = 1'b1;
        end else if (err_clr) begin
            err_underrun_d = 1'b0;
        end

        err_overlap_d = err_overlap_q;
        if (chien_start && pending_q) begin
            err_overlap_d = 1'b1;
        end else if (err_clr) begin
            err_overlap_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_beat_q      <= '0;
            rd_beat_q      <= '0;
            cw_cnt_q       <= '0;
            pending_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_first_q    <= 1'b0;
            out_last_q     <= 1'b0;
            err_underrun_q <= 1'b0;
            err_overlap_q  <= 1'b0;
        end else begin
            wr_beat_q      <= wr_beat_d;
            rd_beat_q      <= rd_beat_d;
            cw_cnt_q       <= cw_cnt_d;
            pending_q      <= pending_d;
            out_valid_q    <= out_valid_d;
            out_first_q    <= out_first_d;
            out_last_q     <= out_last_d;
            err_underrun_q <= err_underrun_d;
            err_overlap_q  <= err_overlap_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/rs_cw_buf_ctrl.md
Name: rs_cw_buf_ctrl

Overview:
- Controller for the decoder's received-codeword delay buffer, which is an external sync_fifo instance.
- Pushes incoming codeword beats into the FIFO while syndrome, key-equation and Chien stages run.
- Counts complete codewords held in the buffer.
- On a Chien-side start request, drains exactly one codeword, beat-aligned with first/last markers, so the error-value correction can XOR it.
- Sits between the RS(544,522) input stream, the buffer FIFO and the Chien/correction stage.

Parameters:
- BEATS_PER_CW, 34, FIFO beats per codeword (544 symbols / 16 symbols per beat); must be >= 2.
- CNT_WIDTH, 3, width of the complete-codeword counter.
- BEAT_WIDTH, 6, width of the beat counters; must satisfy 2^BEAT_WIDTH >= BEATS_PER_CW.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- in_valid  in  1  upstream beat valid; in_data wires straight to FIFO data_in.
- in_ready  out  1  upstream may transfer; equals !fifo_full.
- fifo_push  out  1  FIFO push; equals in_valid && in_ready.
- fifo_pull  out  1  FIFO pull.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- chien_start  in  1  single-cycle request to drain the next codeword.
- out_valid  out  1  FIFO data_out holds a drained beat this cycle.
- out_first  out  1  first beat of a drained codeword; qualified by out_valid.
- out_last  out  1  last beat of a drained codeword; qualified by out_valid.
- busy  out  1  state is DRAIN.
- cw_cnt  out  CNT_WIDTH  complete codewords resident in the FIFO and not yet launched.
- err_clr  in  1  clears both sticky error flags.
- err_underrun  out  1  sticky: start with no complete codeword, or FIFO empty during a drain.
- err_overlap  out  1  sticky: start arrived while one was already pending.

Behaviour:
- Reset (aresetn low at a clock edge): state IDLE; wr_beat=0, rd_beat=0, cw_cnt=0, pending=0; out_valid=out_first=out_last=0; err flags 0. A reset mid-drain abandons the codeword. The FIFO shares aresetn, so FIFO contents are discarded too.
- Write side:
  - in_ready = !fifo_full, combinational; no beat is ever dropped.
  - wr_beat increments on each fifo_push and wraps to 0 after BEATS_PER_CW-1.
  - A push with wr_beat == BEATS_PER_CW-1 completes a codeword (cw_inc).
- State machine: IDLE and DRAIN.
  - launch = (state IDLE && (chien_start || pending)) or (state DRAIN && rd_beat==BEATS_PER_CW-1 && fifo_pull && (chien_start || pending)).
  - A launch with cw_cnt==0: set err_underrun, drop the request, clear pending.
  - A launch with cw_cnt>0: next state DRAIN, rd_beat=0, cw_dec=1.
- Counter: cw_cnt_next = cw_cnt + cw_inc - cw_dec. Simultaneous inc and dec leaves it unchanged. No saturation; the FIFO depth bounds it.
- Pending request:
  - chien_start in DRAIN that is not consumed by a launch sets pending.
  - chien_start while pending is already 1 sets err_overlap; pending stays 1.
- DRAIN:
  - fifo_pull = (state DRAIN) && !fifo_empty, combinational.
  - rd_beat increments on each pull.
  - A pull at rd_beat==BEATS_PER_CW-1 ends the codeword: go to IDLE, or DRAIN again with rd_beat=0 if launch. Back-to-back codewords therefore have no gap.
  - fifo_empty in DRAIN sets err_underrun and stalls; rd_beat holds and the drain resumes when data arrives.
- Output alignment: the FIFO RAM read is registered, so data_out is valid one cycle after the pull.
  - out_valid <= fifo_pull.
  - out_first <= fifo_pull && rd_beat==0.
  - out_last <= fifo_pull && rd_beat==BEATS_PER_CW-1.
- Latency: chien_start at cycle t in IDLE with cw_cnt>0 gives DRAIN at t+1, pulls t+1..t+BEATS_PER_CW, out_valid t+2..t+BEATS_PER_CW+1, with no stalls.
- busy = (state==DRAIN).
- Error flags: err_clr clears both flags. A set event in the same cycle as err_clr wins.

Test Plan (BEATS_PER_CW=4, FIFO ADDR_WIDTH=4):
- Push 4 beats (0xA0..0xA3), then pulse chien_start -> cw_cnt 0->1->0; fifo_pull for 4 cycles; out_valid 4 cycles with data A0..A3; out_first on A0, out_last on A3; busy low afterwards.
- Push 8 beats, chien_start, then chien_start again during the 2nd drain beat -> pending; 8 contiguous out_valid cycles, out_first at beats 0 and 4; no errors; cw_cnt ends at 0.
- chien_start with cw_cnt=0 and 2 beats of a partial codeword present -> err_underrun=1, no pull, stays IDLE; err_clr -> err_underrun=0.
- Three chien_start pulses during one drain with 3 codewords buffered -> err_overlap=1; exactly 2 codewords drained; cw_cnt=1.
- Fill the FIFO to 16 beats with in_valid held high -> in_ready=0 and no 17th push. Start a drain -> in_ready rises after the first pull. The codeword completing on the same cycle as a launch leaves cw_cnt unchanged.
- aresetn low for one cycle at drain beat 2 -> next cycle out_valid=0, busy=0, cw_cnt=0, flags 0; wr_beat restarts at 0.
